// File: rtl/free_list_ctrl_pkg.sv
// Shared sizing and types for the rename-stage physical-register free list.
package free_list_ctrl_pkg;

  localparam int NUM_PREG = 64;
  localparam int NUM_AREG = 32;
  localparam int PREG_W   = $clog2(NUM_PREG);
  localparam int DEPTH    = NUM_PREG - NUM_AREG;
  localparam int PTR_W    = $clog2(DEPTH);

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [PTR_W-1:0]  ptr_t;

  typedef enum logic {FL_INIT, FL_READY} fl_state_e;

endpackage

// File: rtl/free_list_ctrl_fl_fifo.sv
// Free-list storage: DEPTH x W array, two write ports, two combinational
// read ports at raddr and raddr+1. The array carries no reset.
module free_list_ctrl_fl_fifo #(
  parameter int DEPTH = 32,
  parameter int W     = 6,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we0_i,
  input  logic [AW-1:0] waddr0_i,
  input  logic [W-1:0]  wdata0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] waddr1_i,
  input  logic [W-1:0]  wdata1_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata0_o,
  output logic [W-1:0]  rdata1_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] raddr1;

  assign raddr1 = raddr_i + AW'(1);

  always_ff @(posedge clk) begin
    if (we0_i) mem_q[waddr0_i] <= wdata0_i;
    if (we1_i) mem_q[waddr1_i] <= wdata1_i;
  end

  assign rdata0_o = mem_q[raddr_i];
  assign rdata1_o = mem_q[raddr1];

endmodule

// File: rtl/free_list_ctrl.sv
// Physical-register free list for 2-wide rename: circular FIFO with an
// init/flush rebuild FSM, all-or-nothing dual allocation, dual release.
module free_list_ctrl
  import free_list_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              alloc_req_1,
  input  logic              alloc_req_2,
  output logic              alloc_gnt,
  output logic [PREG_W-1:0] pd_1,
  output logic [PREG_W-1:0] pd_2,
  input  logic              rel_en_1,
  input  logic [PREG_W-1:0] rel_preg_1,
  input  logic              rel_en_2,
  input  logic [PREG_W-1:0] rel_preg_2,
  output logic [PREG_W-1:0] free_cnt,
  output logic              ready_o,
  output logic              err_o
);

  localparam preg_t DEPTH_C   = preg_t'(DEPTH);
  localparam ptr_t  LAST_INIT = ptr_t'(DEPTH - 1);

  fl_state_e state_q;
  ptr_t      head_q, tail_q, init_cnt_q;
  preg_t     count_q;
  logic      ready_q, err_q;

  logic [1:0] nreq, npop, nrel, nacc;
  logic       push_1, push_2, ovf;
  preg_t      avail, space, count_d;
  ptr_t       head_d, tail_d;

  logic       wr0_en, wr1_en;
  ptr_t       wr0_addr, wr1_addr;
  preg_t      wr0_data, wr1_data;
  preg_t      rd0_data, rd1_data;

  // Number of pushes that fit into the remaining room; excess is dropped,
  // slot 1 keeping precedence over slot 2.
  function automatic logic [1:0] sat_accept(input logic [1:0] n, input preg_t room);
    if (room < preg_t'(n)) sat_accept = room[1:0];
    else                   sat_accept = n;
  endfunction

  free_list_ctrl_fl_fifo #(
    .DEPTH (DEPTH),
    .W     (PREG_W),
    .AW    (PTR_W)
  ) u_fifo (
    .clk      (clk),
    .we0_i    (wr0_en),
    .waddr0_i (wr0_addr),
    .wdata0_i (wr0_data),
    .we1_i    (wr1_en),
    .waddr1_i (wr1_addr),
    .wdata1_i (wr1_data),
    .raddr_i  (head_q),
    .rdata0_o (rd0_data),
    .rdata1_o (rd1_data)
  );

  // Allocate side: grant only when every requested slot can be served.
  always_comb begin
    nreq      = {1'b0, alloc_req_1} + {1'b0, alloc_req_2};
    alloc_gnt = ready_q && !flush_i && (count_q >= preg_t'(nreq));
    npop      = alloc_gnt ? nreq : 2'd0;
    pd_1      = '0;
    pd_2      = '0;
    if (alloc_gnt) begin
      if (alloc_req_1) begin
        pd_1 = rd0_data;
        pd_2 = rd1_data;
      end else if (alloc_req_2) begin
        pd_2 = rd0_data;
      end
    end
  end

  // Release side: preg 0 is never returned; pushes land after this cycle's pops.
  always_comb begin
    push_1  = ready_q && !flush_i && rel_en_1 && (rel_preg_1 != '0);
    push_2  = ready_q && !flush_i && rel_en_2 && (rel_preg_2 != '0);
    nrel    = {1'b0, push_1} + {1'b0, push_2};
    avail   = count_q - preg_t'(npop);
    space   = DEPTH_C - avail;
    nacc    = sat_accept(nrel, space);
    ovf     = (nacc != nrel);
    head_d  = head_q + ptr_t'(npop);
    tail_d  = tail_q + ptr_t'(nacc);
    count_d = avail + preg_t'(nacc);
  end

  always_comb begin
    wr0_en   = 1'b0;
    wr0_addr = tail_q;
    wr0_data = push_1 ? rel_preg_1 : rel_preg_2;
    wr1_en   = 1'b0;
    wr1_addr = tail_q + ptr_t'(1);
    wr1_data = rel_preg_2;
    if (state_q == FL_INIT) begin
      wr0_en   = !flush_i;
      wr0_addr = init_cnt_q;
      wr0_data = preg_t'(NUM_AREG) + preg_t'(init_cnt_q);
    end else begin
      wr0_en = (nacc != 2'd0);
      wr1_en = (nacc == 2'd2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FL_INIT;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else if (flush_i) begin
      state_q    <= FL_INIT;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        FL_INIT: begin
          tail_q     <= tail_q + ptr_t'(1);
          count_q    <= count_q + preg_t'(1);
          init_cnt_q <= init_cnt_q + ptr_t'(1);
          if (init_cnt_q == LAST_INIT) begin
            state_q <= FL_READY;
            ready_q <= 1'b1;
          end
        end
        FL_READY: begin
          head_q  <= head_d;
          tail_q  <= tail_d;
          count_q <= count_d;
          if (ovf) err_q <= 1'b1;
        end
      endcase
    end
  end

  assign free_cnt = count_q;
  assign ready_o  = ready_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_free_list_ctrl.sv
// Scoreboard bench for free_list_ctrl: a queue-based free-list model predicts
// grants, pd values, count, ready and sticky error every cycle.
module tb_free_list_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush_i;
  logic       alloc_req_1, alloc_req_2;
  logic       alloc_gnt;
  logic [5:0] pd_1, pd_2;
  logic       rel_en_1, rel_en_2;
  logic [5:0] rel_preg_1, rel_preg_2;
  logic [5:0] free_cnt;
  logic       ready_o, err_o;

  always #5 clk = ~clk;

  free_list_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .alloc_req_1 (alloc_req_1),
    .alloc_req_2 (alloc_req_2),
    .alloc_gnt   (alloc_gnt),
    .pd_1        (pd_1),
    .pd_2        (pd_2),
    .rel_en_1    (rel_en_1),
    .rel_preg_1  (rel_preg_1),
    .rel_en_2    (rel_en_2),
    .rel_preg_2  (rel_preg_2),
    .free_cnt    (free_cnt),
    .ready_o     (ready_o),
    .err_o       (err_o)
  );

  typedef struct {
    logic       gnt;
    logic [5:0] pd1;
    logic [5:0] pd2;
    bit         chk2;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] m_fl[$];
  bit         m_ready, m_err;
  int         m_init;
  int         checks = 0;
  int         errors = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock: drive at posedge+1, compare combinational outputs at +4,
  // then compare registered state 1 time unit after the next posedge.
  task automatic cyc(input bit r1, input bit r2, input bit e1, input logic [5:0] p1,
                     input bit e2, input logic [5:0] p2, input bit fl);
    exp_t e;
    exp_t o;
    int   nreq;
    alloc_req_1 = r1;
    alloc_req_2 = r2;
    rel_en_1    = e1;
    rel_preg_1  = p1;
    rel_en_2    = e2;
    rel_preg_2  = p2;
    flush_i     = fl;
    nreq  = int'(r1) + int'(r2);
    e.gnt = m_ready && !fl && (m_fl.size() >= nreq);
    e.pd1 = '0;
    e.pd2 = '0;
    e.chk2 = 1'b1;
    if (e.gnt) begin
      if (r1) begin
        e.pd1 = m_fl[0];
        if (m_fl.size() >= 2) e.pd2 = m_fl[1];
        else e.chk2 = 1'b0;
      end else if (r2) begin
        e.pd2 = m_fl[0];
      end
    end
    exp_q.push_back(e);
    #3;
    o = exp_q.pop_front();
    check_val("alloc_gnt", int'(alloc_gnt), int'(o.gnt));
    check_val("pd_1", int'(pd_1), int'(o.pd1));
    if (o.chk2) check_val("pd_2", int'(pd_2), int'(o.pd2));
    if (fl) begin
      m_fl.delete();
      m_ready = 1'b0;
      m_init  = 0;
    end else if (!m_ready) begin
      m_fl.push_back(6'(32 + m_init));
      m_init++;
      if (m_init == 32) m_ready = 1'b1;
    end else begin
      if (o.gnt) repeat (nreq) void'(m_fl.pop_front());
      if (e1 && p1 != 6'd0) begin
        if (m_fl.size() < 32) m_fl.push_back(p1);
        else m_err = 1'b1;
      end
      if (e2 && p2 != 6'd0) begin
        if (m_fl.size() < 32) m_fl.push_back(p2);
        else m_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_val("free_cnt", int'(free_cnt), m_fl.size());
    check_val("ready_o", int'(ready_o), int'(m_ready));
    check_val("err_o", int'(err_o), int'(m_err));
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
  endtask

  task automatic alloc(input bit r1, input bit r2);
    cyc(r1, r2, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
  endtask

  task automatic do_reset();
    alloc_req_1 = 1'b1;
    alloc_req_2 = 1'b1;
    rst_n = 1'b0;
    #1;
    check_val("rst_ready", int'(ready_o), 0);
    check_val("rst_free", int'(free_cnt), 0);
    check_val("rst_err", int'(err_o), 0);
    check_val("rst_gnt", int'(alloc_gnt), 0);
    check_val("rst_pd_1", int'(pd_1), 0);
    check_val("rst_pd_2", int'(pd_2), 0);
    m_fl.delete();
    m_ready = 1'b0;
    m_err   = 1'b0;
    m_init  = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    alloc_req_1 = 1'b0;
    alloc_req_2 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    flush_i = 1'b0;
    alloc_req_1 = 1'b0;
    alloc_req_2 = 1'b0;
    rel_en_1 = 1'b0;
    rel_en_2 = 1'b0;
    rel_preg_1 = '0;
    rel_preg_2 = '0;
    #1;
    do_reset();

    idle(31);
    check_val("init_not_ready", int'(ready_o), 0);
    idle(1);
    check_val("init_ready", int'(ready_o), 1);
    check_val("init_free32", int'(free_cnt), 32);

    alloc(1'b1, 1'b1);
    alloc(1'b0, 1'b1);
    check_val("free_after_3", int'(free_cnt), 29);

    repeat (14) alloc(1'b1, 1'b1);
    alloc(1'b1, 1'b1);
    check_val("denied_hold", int'(free_cnt), 1);
    alloc(1'b1, 1'b0);
    check_val("empty", int'(free_cnt), 0);

    cyc(1'b1, 1'b0, 1'b1, 6'd5, 1'b1, 6'd0, 1'b0);
    check_val("rel_no_bypass", int'(free_cnt), 1);
    alloc(1'b1, 1'b0);

    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b0, 1'b1, 6'($urandom_range(1, 63)), 1'b1, 6'($urandom_range(1, 63)), 1'b0);
    for (int i = 0; i < 40; i++)
      cyc(1'b1, 1'b1, 1'b1, 6'($urandom_range(1, 63)), 1'b1, 6'($urandom_range(1, 63)), 1'b0);
    check_val("wrap_err", int'(err_o), 0);
    check_val("wrap_free", int'(free_cnt), 20);

    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b0, 1'b1, 6'(i + 40), 1'b1, 6'(i + 50), 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 6'd7, 1'b0, 6'd0, 1'b0);
    check_val("free31", int'(free_cnt), 31);
    cyc(1'b0, 1'b0, 1'b1, 6'd11, 1'b1, 6'd12, 1'b0);
    check_val("ovf_err", int'(err_o), 1);
    check_val("ovf_sat", int'(free_cnt), 32);

    repeat (12) alloc(1'b1, 1'b1);
    alloc(1'b1, 1'b0);
    check_val("pre_flush", int'(free_cnt), 7);
    cyc(1'b1, 1'b1, 1'b1, 6'd9, 1'b1, 6'd10, 1'b1);
    check_val("flush_ready", int'(ready_o), 0);
    check_val("flush_free", int'(free_cnt), 0);
    idle(32);
    check_val("rebuilt_free", int'(free_cnt), 32);
    alloc(1'b1, 1'b0);

    cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
    idle(10);
    do_reset();
    idle(31);
    check_val("reinit_not_ready", int'(ready_o), 0);
    idle(1);
    check_val("reinit_ready", int'(ready_o), 1);
    alloc(1'b1, 1'b1);

    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
          1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
          ($urandom_range(0, 63) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
